// File: rtl/regfile_port_scheduler.sv
// Arbitrates NUM_REQ write requesters and one read requester onto a dual-write-port
// register file. The file latches ReadData only in cycles where neither write port is active.
module regfile_port_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_RD_BURST = 4,
    parameter bit DROP_R0      = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [NUM_REQ-1:0]    WrValid,
    output logic [NUM_REQ-1:0]    WrReady,
    input  logic [5*NUM_REQ-1:0]  WrAddr,
    input  logic [32*NUM_REQ-1:0] WrData,
    input  logic                  RdValid,
    output logic                  RdReady,
    input  logic [4:0]            RdAddr1,
    input  logic [4:0]            RdAddr2,
    output logic                  RdDataValid,
    output logic [31:0]           RdData1,
    output logic [31:0]           RdData2,
    output logic                  RegWrite1,
    output logic                  RegWrite2,
    output logic [4:0]            WriteRegister1,
    output logic [4:0]            WriteRegister2,
    output logic [31:0]           WriteData1,
    output logic [31:0]           WriteData2,
    output logic [4:0]            ReadRegister1,
    output logic [4:0]            ReadRegister2,
    input  logic [31:0]           RfReadData1,
    input  logic [31:0]           RfReadData2
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_RD_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_CAP  = CNT_W'(MAX_RD_BURST);
    localparam logic [IDX_W-1:0] LAST_REQ   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        CycIdle,
        CycRead,
        CycWrite
    } cycleKind_t;

    logic [IDX_W-1:0] rrPtr;
    logic [CNT_W-1:0] burstCnt;
    logic [1:0]       rdPipe;

    logic [4:0]       wrAddrArr [NUM_REQ];
    logic [31:0]      wrDataArr [NUM_REQ];

    cycleKind_t       cycleKind;
    logic             anyWrite;
    logic             burstCapped;

    logic             slot1Valid;
    logic [IDX_W-1:0] slot1Idx;
    logic [4:0]       slot1Addr;
    logic [31:0]      slot1Data;
    logic             slot2Valid;
    logic [IDX_W-1:0] slot2Idx;
    logic [4:0]       slot2Addr;
    logic [31:0]      slot2Data;
    logic             slot1Commit;
    logic             slot2Commit;

    logic [IDX_W-1:0] lastIdx;
    logic [IDX_W-1:0] rrNext;
    logic [NUM_REQ-1:0] wrGrant;

    for (genvar i = 0; i < NUM_REQ; i++) begin : gUnpack
        assign wrAddrArr[i] = WrAddr[5*i +: 5];
        assign wrDataArr[i] = WrData[32*i +: 32];
    end

    assign anyWrite    = |WrValid;
    assign burstCapped = (burstCnt == BURST_CAP) && anyWrite;

    // Reads win unless the burst cap is reached while a write waits.
    always_comb begin
        cycleKind = CycIdle;
        if (RdValid && !burstCapped) begin
            cycleKind = CycRead;
        end else if (anyWrite) begin
            cycleKind = CycWrite;
        end
    end

    // NOTE: every variable gets a default before the scan so no latch is inferred.
    always_comb begin : selectWrites
        logic [IDX_W-1:0] scanIdx;
        slot1Valid = 1'b0;
        slot1Idx   = '0;
        slot1Addr  = '0;
        slot1Data  = '0;
        slot2Valid = 1'b0;
        slot2Idx   = '0;
        slot2Addr  = '0;
        slot2Data  = '0;
        scanIdx    = rrPtr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (WrValid[scanIdx]) begin
                if (!slot1Valid) begin
                    slot1Valid = 1'b1;
                    slot1Idx   = scanIdx;
                    slot1Addr  = wrAddrArr[scanIdx];
                    slot1Data  = wrDataArr[scanIdx];
                end else if (!slot2Valid && (wrAddrArr[scanIdx] != slot1Addr)) begin
                    slot2Valid = 1'b1;
                    slot2Idx   = scanIdx;
                    slot2Addr  = wrAddrArr[scanIdx];
                    slot2Data  = wrDataArr[scanIdx];
                end
            end
            scanIdx = (scanIdx == LAST_REQ) ? '0 : scanIdx + 1'b1;
        end
    end

    // Register-0 writes are still handshaked; only the file-side strobe is suppressed.
    assign slot1Commit = slot1Valid && !(DROP_R0 && (slot1Addr == 5'd0));
    assign slot2Commit = slot2Valid && !(DROP_R0 && (slot2Addr == 5'd0));

    assign lastIdx = slot2Valid ? slot2Idx : slot1Idx;
    assign rrNext  = (lastIdx == LAST_REQ) ? '0 : lastIdx + 1'b1;

    always_comb begin
        wrGrant = '0;
        if (cycleKind == CycWrite) begin
            wrGrant[slot1Idx] = 1'b1;
            if (slot2Valid) begin
                wrGrant[slot2Idx] = 1'b1;
            end
        end
    end

    assign WrReady = Reset_n ? wrGrant : '0;
    assign RdReady = Reset_n && (cycleKind == CycRead);

    // The file samples at the end of the issue cycle, so data lands one stage later.
    assign RdDataValid = rdPipe[1];
    assign RdData1     = rdPipe[1] ? RfReadData1 : '0;
    assign RdData2     = rdPipe[1] ? RfReadData2 : '0;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rrPtr          <= '0;
            burstCnt       <= '0;
            rdPipe         <= '0;
            RegWrite1      <= 1'b0;
            RegWrite2      <= 1'b0;
            WriteRegister1 <= '0;
            WriteRegister2 <= '0;
            WriteData1     <= '0;
            WriteData2     <= '0;
            ReadRegister1  <= '0;
            ReadRegister2  <= '0;
        end else begin
            rdPipe <= {rdPipe[0], (cycleKind == CycRead)};
            case (cycleKind)
                CycWrite: begin
                    rrPtr          <= rrNext;
                    burstCnt       <= '0;
                    RegWrite1      <= slot1Commit;
                    WriteRegister1 <= slot1Addr;
                    WriteData1     <= slot1Data;
                    RegWrite2      <= slot2Commit;
                    if (slot2Valid) begin
                        WriteRegister2 <= slot2Addr;
                        WriteData2     <= slot2Data;
                    end
                end
                CycRead: begin
                    if (burstCnt != BURST_CAP) begin
                        burstCnt <= burstCnt + 1'b1;
                    end
                    RegWrite1     <= 1'b0;
                    RegWrite2     <= 1'b0;
                    ReadRegister1 <= RdAddr1;
                    ReadRegister2 <= RdAddr2;
                end
                default: begin
                    burstCnt  <= '0;
                    RegWrite1 <= 1'b0;
                    RegWrite2 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a small behavioural register file
// that latches ReadData only when both write strobes are low.
`timescale 1ns/1ps
module tb_regfile_port_scheduler;

    localparam int NUM_REQ = 4;

    logic                  Clk = 1'b0;
    logic                  Reset_n;
    logic [NUM_REQ-1:0]    WrValid;
    logic [NUM_REQ-1:0]    WrReady;
    logic [5*NUM_REQ-1:0]  WrAddr;
    logic [32*NUM_REQ-1:0] WrData;
    logic                  RdValid;
    logic                  RdReady;
    logic [4:0]            RdAddr1, RdAddr2;
    logic                  RdDataValid;
    logic [31:0]           RdData1, RdData2;
    logic                  RegWrite1, RegWrite2;
    logic [4:0]            WriteRegister1, WriteRegister2;
    logic [31:0]           WriteData1, WriteData2;
    logic [4:0]            ReadRegister1, ReadRegister2;
    logic [31:0]           RfReadData1 = '0;
    logic [31:0]           RfReadData2 = '0;

    logic [4:0]  wrAddrA [NUM_REQ];
    logic [31:0] wrDataA [NUM_REQ];
    logic [31:0] rfMem   [32];

    int total = 0;
    int bad   = 0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : gPack
        assign WrAddr[5*i +: 5]   = wrAddrA[i];
        assign WrData[32*i +: 32] = wrDataA[i];
    end

    regfile_port_scheduler #(
        .NUM_REQ(NUM_REQ), .MAX_RD_BURST(4), .DROP_R0(1'b1)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .WrValid(WrValid), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData),
        .RdValid(RdValid), .RdReady(RdReady), .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .RdDataValid(RdDataValid), .RdData1(RdData1), .RdData2(RdData2),
        .RegWrite1(RegWrite1), .RegWrite2(RegWrite2),
        .WriteRegister1(WriteRegister1), .WriteRegister2(WriteRegister2),
        .WriteData1(WriteData1), .WriteData2(WriteData2),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RfReadData1(RfReadData1), .RfReadData2(RfReadData2)
    );

    always #5 Clk = ~Clk;

    // Register file: two write ports, ReadData latched only on write-free cycles.
    always @(posedge Clk) begin
        if (RegWrite1) rfMem[WriteRegister1] <= WriteData1;
        if (RegWrite2) rfMem[WriteRegister2] <= WriteData2;
        if (!RegWrite1 && !RegWrite2) begin
            RfReadData1 <= rfMem[ReadRegister1];
            RfReadData2 <= rfMem[ReadRegister2];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic setReq(input logic [1:0] idx, input logic [4:0] addr, input logic [31:0] data);
        wrAddrA[idx] = addr;
        wrDataA[idx] = data;
    endtask

    logic [3:0]  pend;
    logic [11:0] readMask  = 12'b0001_1110_1111;
    logic [11:0] writeMask = 12'b0010_0001_0000;
    logic [11:0] sh;
    logic        expRdv;

    initial begin
        Reset_n = 1'b0;
        RdValid = 1'b1;
        RdAddr1 = 5'd1;
        RdAddr2 = 5'd2;
        WrValid = 4'b1111;
        setReq(2'd0, 5'd1, 32'h1);
        setReq(2'd1, 5'd2, 32'h2);
        setReq(2'd2, 5'd3, 32'h3);
        setReq(2'd3, 5'd4, 32'h4);

        // Reset state with requests pending: no grants, all outputs zero.
        #2;
        check("rst_wrready", WrReady, 4'b0000);
        check("rst_rdready", RdReady, 1'b0);
        check("rst_outs_a", {RegWrite1, RegWrite2, WriteRegister1, WriteRegister2, ReadRegister1, ReadRegister2, RdDataValid}, 64'h0);
        check("rst_outs_b", {WriteData1, WriteData2}, 64'h0);
        step();
        step();
        WrValid = '0;
        RdValid = 1'b0;
        Reset_n = 1'b1;
        step();

        // Two distinct writes granted together from rr_ptr=0.
        setReq(2'd0, 5'd3, 32'hA);
        setReq(2'd1, 5'd7, 32'hB);
        WrValid = 4'b0011;
        #1;
        check("t1_wrready", WrReady, 4'b0011);
        check("t1_rdready", RdReady, 1'b0);
        step();
        check("t1_port1", {RegWrite1, WriteRegister1, WriteData1}, {1'b1, 5'd3, 32'hA});
        check("t1_port2", {RegWrite2, WriteRegister2, WriteData2}, {1'b1, 5'd7, 32'hB});

        // rr_ptr=2: scan 2,3,0 grants 2 then 0; pointer moves to 1.
        setReq(2'd2, 5'd10, 32'hC);
        WrValid = 4'b0111;
        #1;
        check("t1_rr_wrready", WrReady, 4'b0101);
        step();
        check("t1_rr_ports", {WriteRegister1, WriteRegister2}, {5'd10, 5'd3});
        setReq(2'd3, 5'd11, 32'hD);
        WrValid = 4'b1000;
        #1;
        check("t1_rr_single", WrReady, 4'b1000);
        step();
        WrValid = '0;
        step();

        // Same-address conflict: one grant per cycle in order 0..3.
        for (int k = 0; k < 4; k++) begin
            setReq(2'(k), 5'd5, 32'h10 + 32'(k));
        end
        pend = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            WrValid = pend;
            #1;
            check("t2_grant", WrReady, 4'b0001 << k);
            step();
            check("t2_port1", {RegWrite1, WriteRegister1, WriteData1}, {1'b1, 5'd5, 32'h10 + 32'(k)});
            check("t2_port2_idle", RegWrite2, 1'b0);
            pend = pend & ~(4'b0001 << k);
        end
        WrValid = '0;
        step();

        // Register-0 write accepted but not committed.
        setReq(2'd0, 5'd0, 32'h55);
        setReq(2'd1, 5'd4, 32'h44);
        WrValid = 4'b0011;
        #1;
        check("t5_wrready", WrReady, 4'b0011);
        step();
        check("t5_regwrite1", RegWrite1, 1'b0);
        check("t5_port2", {RegWrite2, WriteRegister2, WriteData2}, {1'b1, 5'd4, 32'h44});
        WrValid = '0;
        step();

        // Write r9, then read r9 one cycle later.
        setReq(2'd0, 5'd9, 32'h1234);
        WrValid = 4'b0001;
        #1;
        check("t3_wrready", WrReady, 4'b0001);
        step();
        check("t3_write_issue", {RegWrite1, WriteRegister1, WriteData1}, {1'b1, 5'd9, 32'h1234});
        WrValid = '0;
        RdValid = 1'b1;
        RdAddr1 = 5'd9;
        RdAddr2 = 5'd3;
        #1;
        check("t3_rdready", RdReady, 1'b1);
        check("t3_no_wrready", WrReady, 4'b0000);
        step();
        check("t3_read_issue", {RegWrite1, RegWrite2, ReadRegister1, ReadRegister2, RdDataValid}, {1'b0, 1'b0, 5'd9, 5'd3, 1'b0});
        RdValid = 1'b0;
        step();
        check("t3_rdv", RdDataValid, 1'b1);
        check("t3_rddata", {RdData1, RdData2}, {32'h1234, 32'hA});
        step();
        check("t3_rdv_end", RdDataValid, 1'b0);
        step();

        // Burst cap: RRRRW RRRRW with a write constantly pending.
        setReq(2'd0, 5'd12, 32'h77);
        for (int c = 0; c < 12; c++) begin
            WrValid = (c < 10) ? 4'b0001 : 4'b0000;
            RdValid = (c < 10);
            #1;
            sh = readMask >> c;
            check("t4_rdready", RdReady, sh[0]);
            sh = writeMask >> c;
            check("t4_wrready", WrReady, sh[0] ? 4'b0001 : 4'b0000);
            sh = readMask >> (c - 2);
            expRdv = (c >= 2) ? sh[0] : 1'b0;
            check("t4_rdv", RdDataValid, expRdv);
            if (expRdv) check("t4_rddata", RdData1, 32'h1234);
            step();
        end
        WrValid = '0;
        RdValid = 1'b0;
        step();

        // Reset during an in-flight read.
        RdValid = 1'b1;
        #1;
        check("t6_rdready", RdReady, 1'b1);
        step();
        RdValid = 1'b1;
        WrValid = 4'b1111;
        setReq(2'd0, 5'd20, 32'h200);
        setReq(2'd1, 5'd21, 32'h201);
        setReq(2'd2, 5'd22, 32'h202);
        setReq(2'd3, 5'd23, 32'h203);
        #2;
        Reset_n = 1'b0;
        #1;
        check("t6_outs_a", {RegWrite1, RegWrite2, WriteRegister1, WriteRegister2, ReadRegister1, ReadRegister2, RdDataValid}, 64'h0);
        check("t6_outs_b", {WriteData1, WriteData2}, 64'h0);
        check("t6_readies", {WrReady, RdReady}, 5'b0);
        step();
        RdValid = 1'b0;
        Reset_n = 1'b1;
        #1;
        check("t6_first_grant", WrReady, 4'b0011);
        step();
        check("t6_first_issue", {WriteRegister1, WriteRegister2}, {5'd20, 5'd21});
        check("t6_no_rdv0", RdDataValid, 1'b0);
        WrValid = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("t6_no_rdv", RdDataValid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
